// File: rtl/cam_recon_pkg.sv
// Shared constants and types for the camera reconstruction path.
package cam_recon_pkg;

    localparam int FRAME_WIDTH  = 640;
    localparam int FRAME_HEIGHT = 480;
    localparam int BLOCK_SIZE   = 8;
    localparam int PIXEL_WIDTH  = 8;
    localparam int BLOCKS_X     = (FRAME_WIDTH + BLOCK_SIZE - 1) / BLOCK_SIZE;
    localparam int BLOCKS_Y     = (FRAME_HEIGHT + BLOCK_SIZE - 1) / BLOCK_SIZE;
    localparam int COORD_W      = 10;
    localparam int IDX_W        = $clog2(BLOCK_SIZE * BLOCK_SIZE);
    localparam int ROW_W        = $clog2(BLOCK_SIZE);

    typedef logic [PIXEL_WIDTH-1:0] pixel_t;
    typedef pixel_t [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0] block_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } blk_coord_t;

    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_BUSY = 1'b1
    } drain_state_t;

    // Raster advance: step x, carry into y at the right edge, wrap at the last block.
    function automatic blk_coord_t next_coord(input blk_coord_t c, input blk_coord_t last);
        blk_coord_t n;
        n = c;
        if (c.x == last.x) begin
            n.x = '0;
            n.y = (c.y == last.y) ? '0 : c.y + COORD_W'(1);
        end else begin
            n.x = c.x + COORD_W'(1);
        end
        return n;
    endfunction

endpackage

// File: rtl/recon_block_bank.sv
// One BLOCK_SIZE x BLOCK_SIZE pixel bank with a full flag and a block-position tag.
module recon_block_bank
    import cam_recon_pkg::*;
(
    input  logic                                             i_clk,
    input  logic                                             i_rst_n,
    input  logic                                             i_we,
    input  logic [ROW_W-1:0]                                 i_row,
    input  logic [ROW_W-1:0]                                 i_col,
    input  logic [PIXEL_WIDTH-1:0]                           i_data,
    input  logic                                             i_set_full,
    input  logic                                             i_clr_full,
    input  logic [COORD_W-1:0]                               i_tag_x,
    input  logic [COORD_W-1:0]                               i_tag_y,
    output logic [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][PIXEL_WIDTH-1:0] o_data,
    output logic                                             o_full,
    output logic [COORD_W-1:0]                               o_tag_x,
    output logic [COORD_W-1:0]                               o_tag_y
);

    block_t             r_data;
    logic               r_full;
    logic [COORD_W-1:0] r_tag_x;
    logic [COORD_W-1:0] r_tag_y;

    // Pixel storage carries no reset; consumers only look at it while the bank is full.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_data[i_row][i_col] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full  <= 1'b0;
            r_tag_x <= '0;
            r_tag_y <= '0;
        end else if (i_set_full) begin
            r_full  <= 1'b1;
            r_tag_x <= i_tag_x;
            r_tag_y <= i_tag_y;
        end else if (i_clr_full) begin
            r_full  <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_full  = r_full;
    assign o_tag_x = r_tag_x;
    assign o_tag_y = r_tag_y;

endmodule

// File: rtl/recon_block_collector.sv
// Collects the serial reconstructed pixel stream into double-buffered 8x8 blocks
// and hands each full block, with its raster position, to the frame assembler.
module recon_block_collector
    import cam_recon_pkg::*;
#(
    parameter int FRAME_W = FRAME_WIDTH,
    parameter int FRAME_H = FRAME_HEIGHT
) (
    input  logic                                             clk,
    input  logic                                             reset_n,
    input  logic                                             pix_valid,
    input  logic [PIXEL_WIDTH-1:0]                           pix_data,
    input  logic                                             pix_sof,
    output logic                                             pix_ready,
    output logic [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][PIXEL_WIDTH-1:0] Recon,
    output logic [COORD_W-1:0]                               block_x,
    output logic [COORD_W-1:0]                               block_y,
    output logic                                             start,
    input  logic                                             done,
    output logic                                             frame_done,
    output logic                                             sof_err
);

    localparam int BLK_X = (FRAME_W + BLOCK_SIZE - 1) / BLOCK_SIZE;
    localparam int BLK_Y = (FRAME_H + BLOCK_SIZE - 1) / BLOCK_SIZE;
    localparam blk_coord_t       LAST_POS = '{x: COORD_W'(BLK_X - 1), y: COORD_W'(BLK_Y - 1)};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE * BLOCK_SIZE - 1);

    logic [IDX_W-1:0]   r_idx;
    blk_coord_t         r_pos;
    logic               r_fill_bank;
    logic               r_rd_bank;
    logic               r_frame_done;
    logic               r_sof_err;
    drain_state_t       r_state;
    drain_state_t       w_state_nxt;

    logic               w_accept;
    logic               w_sof_restart;
    logic               w_blk_last;
    logic               w_drain_done;
    logic [IDX_W-1:0]   w_wr_idx;
    logic               w_full  [2];
    block_t             w_data  [2];
    logic [COORD_W-1:0] w_tag_x [2];
    logic [COORD_W-1:0] w_tag_y [2];

    assign w_accept      = pix_valid && pix_ready;
    // A frame start anywhere but the very first pixel slot restarts the frame in place.
    assign w_sof_restart = w_accept && pix_sof && !((r_idx == '0) && (r_pos == '0));
    assign w_wr_idx      = w_sof_restart ? '0 : r_idx;
    assign w_blk_last    = w_accept && !w_sof_restart && (r_idx == LAST_IDX);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        recon_block_bank u_bank (
            .i_clk      (clk),
            .i_rst_n    (reset_n),
            .i_we       (w_accept && (r_fill_bank == 1'(b))),
            .i_row      (w_wr_idx[IDX_W-1:ROW_W]),
            .i_col      (w_wr_idx[ROW_W-1:0]),
            .i_data     (pix_data),
            .i_set_full (w_blk_last && (r_fill_bank == 1'(b))),
            .i_clr_full (w_drain_done && (r_rd_bank == 1'(b))),
            .i_tag_x    (r_pos.x),
            .i_tag_y    (r_pos.y),
            .o_data     (w_data[b]),
            .o_full     (w_full[b]),
            .o_tag_x    (w_tag_x[b]),
            .o_tag_y    (w_tag_y[b])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx       <= '0;
            r_pos       <= '0;
            r_fill_bank <= 1'b0;
            r_sof_err   <= 1'b0;
        end else begin
            r_sof_err <= w_sof_restart;
            if (w_sof_restart) begin
                r_idx <= IDX_W'(1);
                r_pos <= '0;
            end else if (w_blk_last) begin
                r_idx       <= '0;
                r_fill_bank <= ~r_fill_bank;
                r_pos       <= next_coord(r_pos, LAST_POS);
            end else if (w_accept) begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    // Drain FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= DRAIN_IDLE;
            r_rd_bank    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_drain_done &&
                            (w_tag_x[r_rd_bank] == LAST_POS.x) &&
                            (w_tag_y[r_rd_bank] == LAST_POS.y);
            if (w_drain_done) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    // Drain FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DRAIN_IDLE: if (w_full[r_rd_bank]) w_state_nxt = DRAIN_BUSY;
            DRAIN_BUSY: if (done)              w_state_nxt = DRAIN_IDLE;
            default:                           w_state_nxt = DRAIN_IDLE;
        endcase
    end

    // Drain FSM: outputs
    always_comb begin
        start        = (r_state == DRAIN_IDLE) && w_full[r_rd_bank];
        w_drain_done = (r_state == DRAIN_BUSY) && done;
        block_x      = w_tag_x[r_rd_bank];
        block_y      = w_tag_y[r_rd_bank];
        Recon        = w_full[r_rd_bank] ? w_data[r_rd_bank] : '0;
    end

    assign pix_ready  = !w_full[r_fill_bank];
    assign frame_done = r_frame_done;
    assign sof_err    = r_sof_err;

endmodule

// File: tb/tb_recon_block_collector.sv
// Randomized bench for recon_block_collector against a block-level queue model.
module tb_recon_block_collector;

    // Frame height is reduced so that a complete frame fits in a short run.
    localparam int BX = 80;
    localparam int BY = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_data = '0;
    logic        pix_sof = 1'b0;
    logic        done = 1'b0;
    logic        pix_ready;
    logic [7:0][7:0][7:0] Recon;
    logic [9:0]  block_x;
    logic [9:0]  block_y;
    logic        start;
    logic        frame_done;
    logic        sof_err;

    typedef struct packed {
        logic [511:0] px;
        logic [9:0]   bx;
        logic [9:0]   by;
    } exp_t;

    exp_t         exp_q[$];
    logic [511:0] mdl_cur;
    int           mdl_idx;
    int           mdl_blk;
    int           n_tests = 0;
    int           n_fail = 0;

    recon_block_collector #(.FRAME_W(640), .FRAME_H(BY * 8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_sof    (pix_sof),
        .pix_ready  (pix_ready),
        .Recon      (Recon),
        .block_x    (block_x),
        .block_y    (block_y),
        .start      (start),
        .done       (done),
        .frame_done (frame_done),
        .sof_err    (sof_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        mdl_idx = 0;
        mdl_blk = 0;
        mdl_cur = '0;
    endtask

    task automatic model_accept(input logic [7:0] px, input logic sof);
        exp_t e;
        if (sof && !(mdl_idx == 0 && mdl_blk == 0)) begin
            mdl_idx = 0;
            mdl_blk = 0;
        end
        mdl_cur[mdl_idx*8 +: 8] = px;
        mdl_idx++;
        if (mdl_idx == 64) begin
            e.px = mdl_cur;
            e.bx = 10'(mdl_blk % BX);
            e.by = 10'(mdl_blk / BX);
            exp_q.push_back(e);
            mdl_idx = 0;
            mdl_blk = (mdl_blk + 1) % (BX * BY);
        end
    endtask

    task automatic push_pixel(input logic [7:0] px, input logic sof, output bit ok);
        ok = 1'b0;
        pix_valid = 1'b1;
        pix_data  = px;
        pix_sof   = sof;
        for (int t = 0; t < 1000; t++) begin
            if (pix_ready) begin
                tick();
                model_accept(px, sof);
                ok = 1'b1;
                break;
            end
            tick();
        end
        pix_sof = 1'b0;
    endtask

    task automatic send_block(output bit ok);
        bit ok1;
        ok = 1'b1;
        for (int k = 0; k < 64; k++) begin
            push_pixel(8'($urandom), 1'b0, ok1);
            ok &= ok1;
        end
        pix_valid = 1'b0;
    endtask

    task automatic drain_one(output bit ok, output logic [9:0] bx, output logic [9:0] by,
                             output logic [511:0] rec, output logic fd);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (start) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        bx  = block_x;
        by  = block_y;
        rec = Recon;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        fd = frame_done;
    endtask

    task automatic do_reset();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        done      = 1'b0;
        reset_n   = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int c = 0; c < 8; c++) begin
            pix_valid = 1'($urandom);
            pix_sof   = 1'($urandom);
            done      = 1'($urandom);
            pix_data  = 8'($urandom);
            tick();
        end
        n_tests++; if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b expected 0", start); end
        n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        n_tests++; if (sof_err !== 1'b0) begin n_fail++; $display("FAIL reset_sof_err: got %b expected 0", sof_err); end
        n_tests++; if ({block_x, block_y} !== 20'd0) begin n_fail++; $display("FAIL reset_coord: got (%0d,%0d) expected (0,0)", block_x, block_y); end
        n_tests++; if (Recon !== 512'd0) begin n_fail++; $display("FAIL reset_recon: got %0h expected 0", Recon); end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        done      = 1'b0;
        reset_n   = 1'b1;
        model_reset();
        tick();
        n_tests++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", pix_ready); end
    endtask

    task automatic test_single_block();
        bit ok, ok_all;
        logic [511:0] ramp, snap;
        bit stable;
        ok_all = 1'b1;
        for (int k = 0; k < 64; k++) begin
            ramp[k*8 +: 8] = 8'(k);
            push_pixel(8'(k), k == 0, ok);
            ok_all &= ok;
            if (k == 62) begin
                n_tests++; if (start !== 1'b0) begin n_fail++; $display("FAIL single_early_start: got %b expected 0", start); end
            end
        end
        pix_valid = 1'b0;
        n_tests++; if (ok_all !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %b expected 1", ok_all); end
        n_tests++; if (start !== 1'b1) begin n_fail++; $display("FAIL single_start_latency: got %b expected 1", start); end
        n_tests++; if ({block_x, block_y} !== {exp_q[0].bx, exp_q[0].by}) begin n_fail++; $display("FAIL single_coord: got (%0d,%0d) expected (%0d,%0d)", block_x, block_y, exp_q[0].bx, exp_q[0].by); end
        n_tests++; if (Recon !== ramp) begin n_fail++; $display("FAIL single_recon: got %0h expected %0h", Recon, ramp); end
        snap = Recon;
        stable = 1'b1;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (Recon !== snap || start !== 1'b0) stable = 1'b0;
        end
        n_tests++; if (stable !== 1'b1) begin n_fail++; $display("FAIL single_hold: got stable=%b expected 1", stable); end
        done = 1'b1;
        tick();
        done = 1'b0;
        void'(exp_q.pop_front());
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (start !== 1'b0) stable = 1'b0;
            tick();
        end
        n_tests++; if (stable !== 1'b1) begin n_fail++; $display("FAIL single_no_restart: got quiet=%b expected 1", stable); end
        n_tests++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_after: got %b expected 1", pix_ready); end
    endtask

    task automatic test_backpressure();
        bit ok, ok_all, blocked;
        do_reset();
        ok_all = 1'b1;
        for (int k = 0; k < 128; k++) begin
            push_pixel(8'($urandom), 1'b0, ok);
            ok_all &= ok;
        end
        pix_valid = 1'b1;
        pix_data  = 8'($urandom);
        n_tests++; if (ok_all !== 1'b1) begin n_fail++; $display("FAIL bp_accept: got %b expected 1", ok_all); end
        blocked = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (pix_ready !== 1'b0) blocked = 1'b0;
            tick();
        end
        pix_valid = 1'b0;
        n_tests++; if (blocked !== 1'b1) begin n_fail++; $display("FAIL bp_stall: got blocked=%b expected 1", blocked); end
        n_tests++; if (Recon !== exp_q[0].px) begin n_fail++; $display("FAIL bp_recon0: got %0h expected %0h", Recon, exp_q[0].px); end
        done = 1'b1;
        tick();
        done = 1'b0;
        void'(exp_q.pop_front());
        n_tests++; if (start !== 1'b1) begin n_fail++; $display("FAIL bp_start1: got %b expected 1", start); end
        n_tests++; if ({block_x, block_y} !== {10'd1, 10'd0}) begin n_fail++; $display("FAIL bp_coord1: got (%0d,%0d) expected (1,0)", block_x, block_y); end
        n_tests++; if (Recon !== exp_q[0].px) begin n_fail++; $display("FAIL bp_recon1: got %0h expected %0h", Recon, exp_q[0].px); end
        n_tests++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_freed: got %b expected 1", pix_ready); end
        send_block(ok);
        n_tests++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_again: got %b expected 0", pix_ready); end
        done = 1'b1;
        tick();
        done = 1'b0;
        void'(exp_q.pop_front());
        n_tests++; if (start !== 1'b1) begin n_fail++; $display("FAIL bp_start2: got %b expected 1", start); end
        n_tests++; if ({block_x, block_y} !== {10'd2, 10'd0}) begin n_fail++; $display("FAIL bp_coord2: got (%0d,%0d) expected (2,0)", block_x, block_y); end
        n_tests++; if (Recon !== exp_q[0].px) begin n_fail++; $display("FAIL bp_recon2: got %0h expected %0h", Recon, exp_q[0].px); end
    endtask

    task automatic test_raster_wrap();
        bit ok, ok2;
        logic [9:0] bx, by;
        logic [511:0] rec;
        logic fd;
        exp_t e;
        do_reset();
        for (int b = 0; b < 81; b++) begin
            send_block(ok);
            drain_one(ok2, bx, by, rec, fd);
            e = exp_q.pop_front();
            n_tests++; if ((ok && ok2) !== 1'b1) begin n_fail++; $display("FAIL wrap_handshake blk %0d: got %b expected 1", b, ok && ok2); end
            n_tests++; if ({bx, by} !== {e.bx, e.by}) begin n_fail++; $display("FAIL wrap_coord blk %0d: got (%0d,%0d) expected (%0d,%0d)", b, bx, by, e.bx, e.by); end
            n_tests++; if (rec !== e.px) begin n_fail++; $display("FAIL wrap_recon blk %0d: got %0h expected %0h", b, rec, e.px); end
            n_tests++; if (fd !== 1'b0) begin n_fail++; $display("FAIL wrap_frame_done blk %0d: got %b expected 0", b, fd); end
        end
        n_tests++; if ({bx, by} !== {10'd0, 10'd1}) begin n_fail++; $display("FAIL wrap_block81: got (%0d,%0d) expected (0,1)", bx, by); end
    endtask

    task automatic test_full_frame();
        bit ok, ok2;
        logic [9:0] bx, by;
        logic [511:0] rec;
        logic fd, fd_exp;
        int fd_count;
        exp_t e;
        do_reset();
        fd_count = 0;
        for (int b = 0; b < BX * BY; b++) begin
            send_block(ok);
            drain_one(ok2, bx, by, rec, fd);
            e = exp_q.pop_front();
            fd_exp = (e.bx == 10'(BX - 1)) && (e.by == 10'(BY - 1));
            if (fd === 1'b1) fd_count++;
            n_tests++; if ({bx, by} !== {e.bx, e.by}) begin n_fail++; $display("FAIL frame_coord blk %0d: got (%0d,%0d) expected (%0d,%0d)", b, bx, by, e.bx, e.by); end
            n_tests++; if (rec !== e.px) begin n_fail++; $display("FAIL frame_recon blk %0d: got %0h expected %0h", b, rec, e.px); end
            n_tests++; if (fd !== fd_exp) begin n_fail++; $display("FAIL frame_done_blk %0d: got %b expected %b", b, fd, fd_exp); end
        end
        n_tests++; if (fd_count !== 1) begin n_fail++; $display("FAIL frame_done_count: got %0d expected 1", fd_count); end
        tick();
        n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL frame_done_width: got %b expected 0", frame_done); end
        send_block(ok);
        drain_one(ok2, bx, by, rec, fd);
        e = exp_q.pop_front();
        n_tests++; if ({bx, by} !== {10'd0, 10'd0}) begin n_fail++; $display("FAIL frame_next_coord: got (%0d,%0d) expected (0,0)", bx, by); end
        n_tests++; if (rec !== e.px) begin n_fail++; $display("FAIL frame_next_recon: got %0h expected %0h", rec, e.px); end
    endtask

    task automatic test_sof_error();
        bit ok, ok2;
        logic [9:0] bx, by;
        logic [511:0] rec;
        logic fd;
        logic [7:0] v;
        exp_t e;
        do_reset();
        push_pixel(8'($urandom), 1'b1, ok);
        n_tests++; if (sof_err !== 1'b0) begin n_fail++; $display("FAIL sof_normal: got %b expected 0", sof_err); end
        for (int k = 1; k < 64; k++) push_pixel(8'($urandom), 1'b0, ok);
        pix_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            if (b > 0) send_block(ok);
            drain_one(ok2, bx, by, rec, fd);
            e = exp_q.pop_front();
            n_tests++; if ({bx, by} !== {e.bx, e.by}) begin n_fail++; $display("FAIL sof_pre_coord blk %0d: got (%0d,%0d) expected (%0d,%0d)", b, bx, by, e.bx, e.by); end
        end
        for (int k = 0; k < 10; k++) push_pixel(8'($urandom), 1'b0, ok);
        v = 8'($urandom);
        push_pixel(v, 1'b1, ok);
        n_tests++; if (sof_err !== 1'b1) begin n_fail++; $display("FAIL sof_err_pulse: got %b expected 1", sof_err); end
        push_pixel(8'($urandom), 1'b0, ok);
        n_tests++; if (sof_err !== 1'b0) begin n_fail++; $display("FAIL sof_err_width: got %b expected 0", sof_err); end
        for (int k = 0; k < 62; k++) push_pixel(8'($urandom), 1'b0, ok);
        pix_valid = 1'b0;
        drain_one(ok2, bx, by, rec, fd);
        e = exp_q.pop_front();
        n_tests++; if ({bx, by} !== {10'd0, 10'd0}) begin n_fail++; $display("FAIL sof_block_coord: got (%0d,%0d) expected (0,0)", bx, by); end
        n_tests++; if (rec[7:0] !== v) begin n_fail++; $display("FAIL sof_first_pixel: got %0h expected %0h", rec[7:0], v); end
        n_tests++; if (rec !== e.px) begin n_fail++; $display("FAIL sof_block_recon: got %0h expected %0h", rec, e.px); end
    endtask

    task automatic test_reset_mid_drain();
        bit ok, ok2;
        logic [9:0] bx, by;
        logic [511:0] rec;
        logic fd;
        exp_t e;
        do_reset();
        send_block(ok);
        tick();
        for (int k = 0; k < 20; k++) push_pixel(8'($urandom), 1'b0, ok);
        pix_valid = 1'b0;
        reset_n = 1'b0;
        #2;
        n_tests++; if (start !== 1'b0) begin n_fail++; $display("FAIL mid_reset_start: got %b expected 0", start); end
        n_tests++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b expected 1", pix_ready); end
        n_tests++; if (Recon !== 512'd0) begin n_fail++; $display("FAIL mid_reset_recon: got %0h expected 0", Recon); end
        tick();
        reset_n = 1'b1;
        model_reset();
        tick();
        n_tests++; if (start !== 1'b0) begin n_fail++; $display("FAIL mid_reset_stale: got %b expected 0", start); end
        send_block(ok);
        n_tests++; if (start !== 1'b1) begin n_fail++; $display("FAIL mid_reset_restart: got %b expected 1", start); end
        drain_one(ok2, bx, by, rec, fd);
        e = exp_q.pop_front();
        n_tests++; if ({bx, by} !== {10'd0, 10'd0}) begin n_fail++; $display("FAIL mid_reset_coord: got (%0d,%0d) expected (0,0)", bx, by); end
        n_tests++; if (rec !== e.px) begin n_fail++; $display("FAIL mid_reset_recon_data: got %0h expected %0h", rec, e.px); end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_backpressure();
        test_raster_wrap();
        test_full_frame();
        test_sof_error();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
